// File: rtl/msu_pkg.sv
// Shared types and frame-layout helpers for the MSU stream engine.
// Holds the main-state enum, beat-count functions and field offsets.
package msu_pkg;

    typedef enum logic [2:0] {
        INIT,
        RECV,
        LOAD,
        START,
        COMPUTE,
        DRAIN,
        SEND_FINAL,
        DONE
    } state_t;

    function automatic int in_beats(int axi_len, int t_len, int sq_bits);
        return 3 * t_len / axi_len + sq_bits / axi_len;
    endfunction

    function automatic int out_beats(int axi_len, int t_len, int sq_bits);
        return (t_len + sq_bits) / axi_len;
    endfunction

    // Input frame bit offsets (LSB beat first)
    function automatic int off_t_start(int t_len);
        return 0 * t_len;
    endfunction

    function automatic int off_t_final(int t_len);
        return 1 * t_len;
    endfunction

    function automatic int off_ckpt(int t_len);
        return 2 * t_len;
    endfunction

    function automatic int off_sq(int t_len);
        return 3 * t_len;
    endfunction

endpackage

// File: rtl/modular_square_simple.sv
// Behavioural modular squarer: after start, squares its value mod MODULUS
// once per cycle and pulses valid with each new result.
// Ports: clk, reset (sync, active-high), start, sq_in -> sq_out, valid.
module modular_square_simple #(
    parameter int          MOD_LEN = 1024,
    parameter int unsigned MODULUS = 1000003
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MOD_LEN-1:0] sq_in,
    output logic [MOD_LEN-1:0] sq_out,
    output logic               valid
);

    localparam logic [2*MOD_LEN-1:0] MOD_W = (2*MOD_LEN)'(MODULUS);

    logic [2*MOD_LEN-1:0] prod;
    logic                 running;

    assign prod = {{MOD_LEN{1'b0}}, sq_out} * {{MOD_LEN{1'b0}}, sq_out};

    always_ff @(posedge clk) begin
        if (reset) begin
            running <= 1'b0;
            valid   <= 1'b0;
        end else if (start) begin
            running <= 1'b1;
            valid   <= 1'b0;
        end else if (running) begin
            valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            sq_out <= sq_in;
        end else if (running) begin
            sq_out <= MOD_LEN'(prod % MOD_W);
        end
    end

endmodule

// File: rtl/modular_square_wrapper.sv
// Squarer wrapper presenting the engine-facing squarer interface.
// Ports: clk, reset (sync, active-high), start, sq_in -> sq_out, valid.
module modular_square_wrapper #(
    parameter int          MOD_LEN = 1024,
    parameter int unsigned MODULUS = 1000003
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MOD_LEN-1:0] sq_in,
    output logic [MOD_LEN-1:0] sq_out,
    output logic               valid
);

    modular_square_simple #(
        .MOD_LEN (MOD_LEN),
        .MODULUS (MODULUS)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .sq_in  (sq_in),
        .sq_out (sq_out),
        .valid  (valid)
    );

endmodule

// File: rtl/msu_out_buf.sv
// Output frame buffer: loads a whole frame, shifts it out LSB beat first.
// Ports: load/load_data in, busy out; AXI-stream tvalid/tready/tdata/tlast.
module msu_out_buf #(
    parameter int DATA_W = 64,
    parameter int BEATS  = 3
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic [BEATS*DATA_W-1:0] load_data,
    output logic                    busy,
    output logic                    tvalid,
    input  logic                    tready,
    output logic [DATA_W-1:0]       tdata,
    output logic                    tlast
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    logic [BEATS*DATA_W-1:0] shreg;
    logic [CW-1:0]           cnt;
    logic                    hs;

    assign hs     = busy && tready;
    assign tvalid = busy;
    assign tlast  = busy && (cnt == LAST);
    assign tdata  = shreg[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (load && !busy) begin
            busy <= 1'b1;
            cnt  <= '0;
        end else if (hs) begin
            if (cnt == LAST) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load && !busy) begin
            shreg <= load_data;
        end else if (hs) begin
            shreg <= shreg >> DATA_W;
        end
    end

endmodule

// File: rtl/msu_stream.sv
// Streaming modular-squaring engine: receives a job frame, iterates the
// squarer from t_start to t_final, emits checkpoint and final frames.
// Ports: s_axis_* job input, m_axis_* result output, ap_start/ap_done,
// start_xfer per loaded frame, frame_err, ckpt_drop_count, xfer sizes.
module msu_stream
    import msu_pkg::*;
#(
    parameter int AXI_LEN           = 64,
    parameter int C_XFER_SIZE_WIDTH = 32,
    parameter int SQ_BITS           = 1024,
    parameter int T_LEN             = 64
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [AXI_LEN-1:0]           s_axis_tdata,
    input  logic [AXI_LEN/8-1:0]         s_axis_tkeep,
    input  logic                         s_axis_tlast,
    output logic [C_XFER_SIZE_WIDTH-1:0] s_axis_xfer_size_in_bytes,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [AXI_LEN-1:0]           m_axis_tdata,
    output logic [AXI_LEN/8-1:0]         m_axis_tkeep,
    output logic                         m_axis_tlast,
    output logic [C_XFER_SIZE_WIDTH-1:0] m_axis_xfer_size_in_bytes,
    input  logic                         ap_start,
    output logic                         ap_done,
    output logic                         start_xfer,
    output logic                         frame_err,
    output logic [15:0]                  ckpt_drop_count
);

    localparam int IN_BEATS  = in_beats(AXI_LEN, T_LEN, SQ_BITS);
    localparam int OUT_BEATS = out_beats(AXI_LEN, T_LEN, SQ_BITS);
    localparam int IN_W      = IN_BEATS * AXI_LEN;
    localparam int OUT_W     = OUT_BEATS * AXI_LEN;
    localparam int BC_W      = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
    localparam int OFF_TS    = off_t_start(T_LEN);
    localparam int OFF_TF    = off_t_final(T_LEN);
    localparam int OFF_CK    = off_ckpt(T_LEN);
    localparam int OFF_SQ    = off_sq(T_LEN);
    localparam logic [BC_W-1:0] LAST_BEAT = BC_W'(IN_BEATS - 1);

    state_t state, state_nx;

    logic [BC_W-1:0]    beat_cnt;
    logic [IN_W-1:0]    in_buf;
    logic [T_LEN-1:0]   t_cur, t_final, ckpt_ival, ckpt_cnt, t_next;
    logic [T_LEN-1:0]   f_ts, f_tf, f_ck;
    logic [SQ_BITS-1:0] f_sq, sq_cur, sq_res;
    logic               sq_rst, sq_start, sq_valid, sq_step;
    logic               in_hs, in_last, ckpt_hit;
    logic               ob_load, ob_busy;
    logic [OUT_W-1:0]   ob_data;
    logic               unused_keep;

    assign unused_keep = ^s_axis_tkeep;

    assign s_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(IN_BEATS * AXI_LEN / 8);
    assign m_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(OUT_BEATS * AXI_LEN / 8);
    assign m_axis_tkeep              = '1;

    assign s_axis_tready = (state == RECV);
    assign ap_done       = (state == DONE);
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign in_last       = (beat_cnt == LAST_BEAT);

    assign f_ts = in_buf[OFF_TS +: T_LEN];
    assign f_tf = in_buf[OFF_TF +: T_LEN];
    assign f_ck = in_buf[OFF_CK +: T_LEN];
    assign f_sq = in_buf[OFF_SQ +: SQ_BITS];

    assign sq_start = (state == START);
    assign sq_rst   = !reset_n || !((state == START) || (state == COMPUTE));

    // A valid arriving once t_final is reached belongs to no iteration
    assign sq_step  = (state == COMPUTE) && sq_valid && (t_cur != t_final);
    assign t_next   = t_cur + T_LEN'(1);
    assign ckpt_hit = sq_step && (ckpt_ival != '0) &&
                      (ckpt_cnt == T_LEN'(1)) && (t_next != t_final);

    always_comb begin
        state_nx = state;
        ob_load  = 1'b0;
        ob_data  = {sq_cur, t_cur};
        unique case (state)
            INIT: if (ap_start) state_nx = RECV;
            RECV: begin
                if (in_hs) begin
                    if (in_last) state_nx = LOAD;
                    else if (s_axis_tlast) state_nx = INIT;
                end
            end
            LOAD: state_nx = (f_tf <= f_ts) ? DRAIN : START;
            START: state_nx = COMPUTE;
            COMPUTE: begin
                if (t_cur == t_final) state_nx = DRAIN;
                if (ckpt_hit && !ob_busy) begin
                    ob_load = 1'b1;
                    ob_data = {sq_res, t_next};
                end
            end
            DRAIN: begin
                if (!ob_busy) begin
                    ob_load  = 1'b1;
                    state_nx = SEND_FINAL;
                end
            end
            SEND_FINAL: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
                    state_nx = DONE;
            end
            DONE: state_nx = INIT;
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= INIT;
            beat_cnt        <= '0;
            t_cur           <= '0;
            t_final         <= '0;
            ckpt_ival       <= '0;
            ckpt_cnt        <= '0;
            frame_err       <= 1'b0;
            start_xfer      <= 1'b0;
            ckpt_drop_count <= '0;
        end else begin
            state      <= state_nx;
            start_xfer <= ob_load;
            if (state == INIT && ap_start) begin
                frame_err <= 1'b0;
                beat_cnt  <= '0;
            end
            if (state == RECV && in_hs) begin
                beat_cnt <= beat_cnt + BC_W'(1);
                if (!in_last && s_axis_tlast) frame_err <= 1'b1;
            end
            if (state == LOAD) begin
                t_cur     <= f_ts;
                t_final   <= f_tf;
                ckpt_ival <= f_ck;
                ckpt_cnt  <= f_ck;
            end
            if (sq_step) begin
                t_cur    <= t_next;
                ckpt_cnt <= (ckpt_cnt == T_LEN'(1)) ? ckpt_ival
                                                    : ckpt_cnt - T_LEN'(1);
            end
            // Squaring never stalls: a snapshot with no room is lost
            if (ckpt_hit && ob_busy && ckpt_drop_count != 16'hFFFF)
                ckpt_drop_count <= ckpt_drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == RECV && in_hs)
            in_buf <= {s_axis_tdata, in_buf[IN_W-1:AXI_LEN]};
        if (state == LOAD)
            sq_cur <= f_sq;
        else if (sq_step)
            sq_cur <= sq_res;
    end

`ifdef SIMPLE_SQ
    modular_square_simple #(
        .MOD_LEN (SQ_BITS)
    ) u_sq (
        .clk    (clk),
        .reset  (sq_rst),
        .start  (sq_start),
        .sq_in  (sq_cur),
        .sq_out (sq_res),
        .valid  (sq_valid)
    );
`else
    modular_square_wrapper #(
        .MOD_LEN (SQ_BITS)
    ) u_sq (
        .clk    (clk),
        .reset  (sq_rst),
        .start  (sq_start),
        .sq_in  (sq_cur),
        .sq_out (sq_res),
        .valid  (sq_valid)
    );
`endif

    msu_out_buf #(
        .DATA_W (AXI_LEN),
        .BEATS  (OUT_BEATS)
    ) u_out_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (ob_load),
        .load_data (ob_data),
        .busy      (ob_busy),
        .tvalid    (m_axis_tvalid),
        .tready    (m_axis_tready),
        .tdata     (m_axis_tdata),
        .tlast     (m_axis_tlast)
    );

endmodule

// File: tb/tb_msu_stream.sv
// Directed bench for msu_stream (AXI_LEN=64, T_LEN=64, SQ_BITS=128).
// Ports: drives job frames and output back-pressure, checks result frames.
module tb_msu_stream;

    localparam longint unsigned N = 1000003;
    localparam logic [127:0] BIG = 128'h0123456789abcdeffedcba9876543210;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = 8'hFF;
    logic        s_tlast = 1'b0;
    logic [31:0] s_xfer;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tlast;
    logic [31:0] m_xfer;
    logic        ap_done, start_xfer, frame_err;
    logic [15:0] drops;

    int errs = 0;
    int checks = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    int mode = 0;
    int idx = 0;
    bit stall = 0;
    logic [63:0]  stall_data;
    logic [191:0] cur;
    logic [63:0]  q_t[$];
    logic [127:0] q_sq[$];

    msu_stream #(
        .AXI_LEN(64), .C_XFER_SIZE_WIDTH(32), .SQ_BITS(128), .T_LEN(64)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep),
        .s_axis_tlast(s_tlast), .s_axis_xfer_size_in_bytes(s_xfer),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_xfer_size_in_bytes(m_xfer),
        .ap_start(ap_start), .ap_done(ap_done), .start_xfer(start_xfer),
        .frame_err(frame_err), .ckpt_drop_count(drops)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] sqpow(input longint unsigned b,
                                           input int k);
        longint unsigned v;
        v = b % N;
        repeat (k) v = (v * v) % N;
        return 128'(v);
    endfunction

    // Output back-pressure pattern, updated just after each edge
    initial forever begin
        @(posedge clk);
        #1;
        case (mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'b0;
            default: m_tready = ~m_tready;
        endcase
    end

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset_n) begin
            idx   = 0;
            stall = 0;
        end else begin
            if (ap_done) done_cnt++;
            if (start_xfer) xfer_cnt++;
            if (m_tvalid && stall) chk("hold", m_tdata, stall_data);
            if (m_tvalid && m_tready) begin
                chk("tlast", m_tlast, idx == 2);
                cur[idx*64 +: 64] = m_tdata;
                if (idx == 2) begin
                    q_t.push_back(cur[63:0]);
                    q_sq.push_back(cur[191:64]);
                    idx = 0;
                end else begin
                    idx++;
                end
            end
            stall      = m_tvalid && !m_tready;
            stall_data = m_tdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [63:0] ts, input logic [63:0] tf,
                          input logic [63:0] ck, input logic [127:0] sq,
                          input int nb, input int last_at);
        logic [319:0] f;
        bit ok;
        int n;
        f = {sq, ck, tf, ts};
        ap_start = 1'b1;
        tick(1);
        ap_start = 1'b0;
        for (int i = 0; i < nb; i++) begin
            s_tdata  = f[i*64 +: 64];
            s_tlast  = (i == last_at);
            s_tvalid = 1'b1;
            ok = 0;
            n  = 0;
            while (!ok && n < 100) begin
                @(negedge clk);
                ok = s_tready;
                tick(1);
                n++;
            end
            if (!ok) chk("s_hs_timeout", 0, 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (done_cnt == prev && n < 3000) begin
            tick(1);
            n++;
        end
        chk("done_seen", done_cnt != prev, 1);
        tick(3);
        chk("done_once", done_cnt, prev + 1);
    endtask

    task automatic expect_frame(input string tag, input logic [63:0] t,
                                input logic [127:0] sq);
        if (q_t.size() == 0) begin
            chk({tag, "_missing"}, 0, 1);
        end else begin
            chk({tag, "_t"}, q_t.pop_front(), t);
            chk({tag, "_sq"}, q_sq.pop_front(), sq);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_s_tready"}, s_tready, 0);
        chk({tag, "_m_tvalid"}, m_tvalid, 0);
        chk({tag, "_m_tlast"}, m_tlast, 0);
        chk({tag, "_ap_done"}, ap_done, 0);
        chk({tag, "_start_xfer"}, start_xfer, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_drops"}, drops, 0);
    endtask

    task automatic pulse_reset(input string tag);
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_idle(tag);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        int d0, x0, n;
        tick(3);
        @(negedge clk);
        chk_idle("rst");
        chk("in_size", s_xfer, 40);
        chk("out_size", m_xfer, 24);
        chk("tkeep", m_tkeep, 8'hFF);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tick(2);

        // Plain run, no checkpoints
        d0 = done_cnt; x0 = xfer_cnt;
        launch(0, 4, 0, 2, 5, 4);
        wait_done(d0);
        expect_frame("t1", 4, 65536);
        chk("t1_left", q_t.size(), 0);
        chk("t1_xfer", xfer_cnt - x0, 1);

        // Checkpoint every 2 iterations
        d0 = done_cnt; x0 = xfer_cnt;
        launch(0, 4, 2, 2, 5, 4);
        wait_done(d0);
        expect_frame("t2a", 2, 16);
        expect_frame("t2b", 4, 65536);
        chk("t2_left", q_t.size(), 0);
        chk("t2_xfer", xfer_cnt - x0, 2);
        chk("t2_drops", drops, 0);

        // Stalled output: later checkpoints are dropped
        mode = 1;
        d0 = done_cnt; x0 = xfer_cnt;
        launch(0, 20, 1, 2, 5, 4);
        tick(80);
        chk("t3_drops", drops, 18);
        chk("t3_pending", m_tvalid, 1);
        mode = 0;
        wait_done(d0);
        expect_frame("t3a", 1, 4);
        expect_frame("t3b", 20, sqpow(2, 20));
        chk("t3_left", q_t.size(), 0);
        chk("t3_xfer", xfer_cnt - x0, 2);

        // Alternating back-pressure
        mode = 2;
        d0 = done_cnt;
        launch(3, 9, 3, 5, 5, 4);
        wait_done(d0);
        mode = 0;
        expect_frame("t4a", 6, sqpow(5, 3));
        expect_frame("t4b", 9, sqpow(5, 6));
        chk("t4_left", q_t.size(), 0);
        chk("t4_drops", drops, 18);

        // Early tlast aborts the frame
        d0 = done_cnt; x0 = xfer_cnt;
        launch(0, 4, 0, 2, 3, 2);
        tick(20);
        chk("t5_err", frame_err, 1);
        chk("t5_idle", s_tready, 0);
        chk("t5_done", done_cnt, d0);
        chk("t5_xfer", xfer_cnt - x0, 0);
        chk("t5_left", q_t.size(), 0);

        // t_final == t_start passes sq_in straight through
        d0 = done_cnt;
        launch(7, 7, 0, BIG, 5, 4);
        wait_done(d0);
        chk("t5b_err", frame_err, 0);
        expect_frame("t5b", 7, BIG);
        chk("t5b_left", q_t.size(), 0);

        // Reset during COMPUTE
        d0 = done_cnt;
        launch(0, 1000, 0, 3, 5, 4);
        tick(10);
        pulse_reset("r1");
        tick(30);
        chk("r1_left", q_t.size(), 0);
        chk("r1_done", done_cnt, d0);

        // Reset during SEND_FINAL
        mode = 1;
        launch(0, 4, 0, 2, 5, 4);
        n = 0;
        while (!m_tvalid && n < 200) begin
            tick(1);
            n++;
        end
        chk("r2_pending", m_tvalid, 1);
        pulse_reset("r2");
        mode = 0;
        tick(20);
        chk("r2_left", q_t.size(), 0);
        chk("r2_done", done_cnt, d0);

        // Clean run after resets
        d0 = done_cnt; x0 = xfer_cnt;
        launch(0, 4, 0, 2, 5, 4);
        wait_done(d0);
        expect_frame("t6", 4, 65536);
        chk("t6_left", q_t.size(), 0);
        chk("t6_xfer", xfer_cnt - x0, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/msu_stream.md
MSU_STREAM -- requirements
Module: msu_stream

Interface
REQ-001 Parameter AXI_LEN, 64, AXI stream data width in bits (power of two, 32..512).
REQ-002 Parameter C_XFER_SIZE_WIDTH, 32, width of the transfer-size outputs.
REQ-003 Parameter SQ_BITS, 1024, modulus and squaring operand width (a multiple of AXI_LEN).
REQ-004 Parameter T_LEN, 64, iteration counter width (a multiple of AXI_LEN).
REQ-005 clk  in  1  single clock; reset_n  in  1  reset, synchronous, active-low.
REQ-006 s_axis_tvalid/tready/tdata[AXI_LEN]/tkeep[AXI_LEN/8]/tlast  in/out/in/in/in  input stream; tkeep ignored.
REQ-007 s_axis_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  constant IN_BEATS*AXI_LEN/8.
REQ-008 m_axis_tvalid/tready/tdata[AXI_LEN]/tkeep[AXI_LEN/8]/tlast  out/in/out/out/out  output stream.
REQ-009 m_axis_xfer_size_in_bytes  out  C_XFER_SIZE_WIDTH  constant OUT_BEATS*AXI_LEN/8 (per frame).
REQ-010 ap_start in 1; ap_done out 1; start_xfer out 1, one-cycle pulse per output frame loaded.
REQ-011 frame_err  out  1  sticky until next ap_start; ckpt_drop_count  out  16  saturating checkpoint drop count.

Function
REQ-012 Input frame, LSB beat first: t_start, t_final, ckpt_interval (T_LEN each), then sq_in (SQ_BITS); IN_BEATS = 3*T_LEN/AXI_LEN + SQ_BITS/AXI_LEN.
REQ-013 Output frame, LSB beat first: t_value (T_LEN), then sq_value (SQ_BITS); OUT_BEATS = (T_LEN+SQ_BITS)/AXI_LEN; m_axis_tlast=1 on the final beat only; m_axis_tkeep all ones.
REQ-014 Main FSM states: INIT, RECV, LOAD, START, COMPUTE, DRAIN, SEND_FINAL, DONE.
REQ-015 INIT->RECV on ap_start; s_axis_tready=1 only in RECV; a beat counts only on tvalid&&tready.
REQ-016 RECV->LOAD on acceptance of beat IN_BEATS-1; tlast=1 on any earlier beat sets frame_err and returns to INIT; tlast=0 on the last beat is not an error.
REQ-017 LOAD: latch fields; if t_final<=t_start, go to DRAIN with sq_out taken as sq_in and t_current=t_start (no squaring); otherwise go to START.
REQ-018 START: one-cycle start pulse to the squarer, then COMPUTE; squarer reset held high outside START/COMPUTE.
REQ-019 COMPUTE: each squarer valid pulse sets t_current <= t_current+1; COMPUTE->DRAIN in the cycle t_current==t_final.
REQ-020 Checkpoint: ckpt_interval=0 disables checkpoints; otherwise a down-counter loaded with ckpt_interval decrements on each valid and reloads on reaching 0; on a valid where it reaches 0 and t_current+1 != t_final, {sq_out, t_current+1} is captured in that same cycle into the output buffer.
REQ-021 Checkpoint capture while the output buffer is busy: snapshot discarded, ckpt_drop_count +1 (saturating at 0xFFFF); squaring never stalls.
REQ-022 DRAIN: wait until the output buffer is idle, load {sq_out, t_current}, then SEND_FINAL; SEND_FINAL->DONE on handshake of the final beat of that frame.
REQ-023 DONE: ap_done=1 for exactly one cycle, then INIT.
REQ-024 Output buffer: the shift register advances and the beat counter increments only on m_axis_tvalid&&m_axis_tready; m_axis_tdata is held stable while tvalid=1 and tready=0.
REQ-025 start_xfer pulses in the cycle after each frame load (checkpoint or final).
REQ-026 ap_start outside INIT is ignored; t_current wraps modulo 2^T_LEN.

Reset
REQ-027 reset_n=0 at any clock edge, mid-operation included: main FSM INIT, output buffer idle, counters 0, squarer reset; the partial frame is discarded.
REQ-028 Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, ap_done=0, start_xfer=0, frame_err=0, ckpt_drop_count=0.

Structure
REQ-029 The package msu_pkg holds the main-state enum, IN_BEATS/OUT_BEATS localparam functions and the frame-layout offsets.
REQ-030 Sub-module msu_out_buf: load/busy interface, shift register, beat counter, tvalid/tlast generation.
REQ-031 The squarer is modular_square_wrapper, or modular_square_simple under SIMPLE_SQ, with MOD_LEN=SQ_BITS.

Verification (AXI_LEN=64, T_LEN=64, SQ_BITS=128, SIMPLE_SQ, modulus 1000003)
REQ-032 t_start=0, t_final=4, ckpt=0, sq_in=2, tready=1 -> one frame {t=4, sq=2^16 mod N}; tlast on beat 2; ap_done pulses once.
REQ-033 Same input with ckpt=2 -> frames t=2 (sq=16), then t=4; two start_xfer pulses; ckpt_drop_count=0.
REQ-034 t_final=20, ckpt=1, m_axis_tready held 0 until t_current=20 -> one checkpoint frame (t=1), drops=18, final frame t=20.
REQ-035 m_axis_tready toggled 1010... -> every beat delivered exactly once, in order, data stable while stalled.
REQ-036 tlast on input beat 3 of 5 -> frame_err=1, FSM returns to INIT, no output frame; t_start=7, t_final=7 -> immediate frame {t=7, sq=sq_in}.
REQ-037 reset_n pulsed low during COMPUTE and again mid-SEND_FINAL -> all outputs at reset values next cycle; a following run completes correctly.
